stream_sorter: RTL and testbench
================================

Name: stream_sorter

Overview:
- Parametrised sequential successor to the team's 3-bit min-select comparator.
- Loads a batch of DEPTH WIDTH-bit values over a valid/ready stream and sorts them in place with an odd-even transposition network (one phase per cycle).
- Drains the batch in sorted order over a second valid/ready stream.
- Sort direction (ascending/descending) is selected per batch.

Parameters:
- WIDTH, 3, bit width of each data value.
- DEPTH, 8, values per batch; must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream value valid.
- in_ready  output  1  block accepts a value this cycle.
- in_data  input  WIDTH  value being loaded.
- desc  input  1  sort direction, 1 = descending; sampled on the first accepted beat of a batch.
- out_valid  output  1  sorted value available.
- out_ready  input  1  downstream accepts a value.
- out_data  output  WIDTH  sorted value.
- out_last  output  1  high with the final value of a batch.
- busy  output  1  high in SORT or DRAIN.

Behaviour:
- Reset (rst high at a clock edge):
  - state = LOAD; wr_cnt, phase_cnt and rd_cnt = 0; desc_q = 0.
  - Array contents are don't-care.
  - While rst is high: in_ready = 0, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
- Reset mid-operation: any state returns to LOAD and the partial batch is discarded. No further out_valid occurs for that batch.
- A transfer happens on valid & ready. Data is sampled only on a transfer.
- LOAD:
  - in_ready = 1, busy = 0.
  - Each transfer writes mem[wr_cnt] and increments wr_cnt.
  - When wr_cnt = 0, desc is latched into desc_q.
  - On the DEPTH-th transfer: wr_cnt returns to 0 and the next state is SORT.
- SORT:
  - in_ready = 0, busy = 1. Lasts exactly DEPTH cycles (phase_cnt 0..DEPTH-1).
  - Even phase compares pairs (0,1), (2,3), ... Odd phase compares pairs (1,2), (3,4), ..., (DEPTH-3, DEPTH-2).
  - Ascending: swap when mem[i] > mem[i+1]. Descending: swap when mem[i] < mem[i+1].
  - Equal values never swap.
  - After phase DEPTH-1 the next state is DRAIN.
- DRAIN:
  - in_ready = 0, busy = 1, out_valid = 1, out_data = mem[rd_cnt].
  - out_last = 1 when rd_cnt = DEPTH-1.
  - rd_cnt advances only on an output transfer.
  - out_data and out_last stay stable while out_valid & !out_ready.
  - After the transfer with out_last = 1: rd_cnt = 0, next state is LOAD, and in_ready = 1 on the following cycle.
- Outside DRAIN: out_valid = 0, out_data = 0, out_last = 0.
- Latency: if the last input transfer occurs at edge t, out_valid is first high in the cycle after edge t+DEPTH (DEPTH sort cycles). Throughput is one value per cycle in LOAD and DRAIN.
- The block does not overlap batches: loading and draining are mutually exclusive.
- Comparison is unsigned by default.
- Counter widths are $clog2(DEPTH) with no wrap beyond DEPTH-1.

Optional Feature:
- Macro: STREAM_SORTER_SIGNED_EN.
- Defined: values are compared as two's-complement signed WIDTH-bit numbers.
- Undefined: unsigned comparison.
- All other behaviour and timing are identical in both builds.

Decomposition:
- Package sorter_pkg:
  - State enum {LOAD, SORT, DRAIN}.
  - Constant SORT_PHASES = DEPTH.
  - Helper function for the counter width.
- Sub-module cmp_swap (params WIDTH):
  - Inputs: a, b, desc.
  - Outputs: lo_slot, hi_slot.
  - Purely combinational ordered pair; the signed/unsigned compare is selected by the macro.
  - The top level instantiates DEPTH/2 instances for even phases and DEPTH/2-1 for odd phases.

Test Plan (WIDTH=3, DEPTH=8):
- Ascending sort: desc=0, load 5,3,7,0,6,1,4,2 with out_ready=1 -> out_data 0,1,2,3,4,5,6,7; out_last only on 7; first out_valid 8 cycles after the edge carrying the last input; in_ready=0 throughout SORT/DRAIN.
- Descending with duplicates: desc=1, load 3,3,0,7,7,1,1,5 -> 7,7,5,3,3,1,1,0; desc toggled mid-load has no effect.
- Backpressure: out_ready pattern 1,0,0,1,0,1,... -> exactly 8 transfers, no duplicate or dropped values; out_data stable while stalled; in_ready rises the cycle after the out_last transfer.
- Reset mid-SORT (rst at phase 3) -> next cycle out_valid=0, busy=0; in_ready=1 after rst deasserts; a fresh batch 7,6,5,4,3,2,1,0 ascending drains 0..7.
- Signed build with STREAM_SORTER_SIGNED_EN: ascending load 3'b011,3'b100,3'b111,3'b000,3'b010,3'b101,3'b001,3'b110 -> 100,101,110,111,000,001,010,011. Same stimulus in the unsigned build -> 000..111 in numeric order.
- Back-to-back batches with in_valid held high -> second batch is accepted immediately after the first drains, and both sorted outputs are correct.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and sizing helpers for the stream sorter.
package sorter_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Counter width for an index range 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One transposition phase per element guarantees a fully sorted array.
    function automatic int unsigned sort_phases(input int unsigned depth);
        return depth;
    endfunction

endpackage

// File: rtl/stream_sorter_cmp_swap.sv
// Combinational compare-and-swap: lo_slot takes the element that belongs first.
// STREAM_SORTER_SIGNED_EN selects two's-complement comparison.
module cmp_swap #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             desc,
    output logic [WIDTH-1:0] lo_slot,
    output logic [WIDTH-1:0] hi_slot
);

    logic a_gt_b;
    logic a_lt_b;
    logic swap;

`ifdef STREAM_SORTER_SIGNED_EN
    assign a_gt_b = $signed(a) > $signed(b);
    assign a_lt_b = $signed(a) < $signed(b);
`else
    assign a_gt_b = a > b;
    assign a_lt_b = a < b;
`endif

    // Equal values fall through unswapped in either direction.
    assign swap    = desc ? a_lt_b : a_gt_b;
    assign lo_slot = swap ? b : a;
    assign hi_slot = swap ? a : b;

endmodule

// File: rtl/stream_sorter.sv
// Batch sorter: load DEPTH values, odd-even transposition sort in place, drain in order.
// Build option STREAM_SORTER_SIGNED_EN switches to signed comparison.
module stream_sorter
    import sorter_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             desc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned CW          = cnt_width(DEPTH);
    localparam int unsigned SORT_PHASES = sort_phases(DEPTH);
    localparam int unsigned NPAIR_EVEN  = DEPTH / 2;
    localparam int          NPAIR_ODD   = int'(DEPTH / 2) - 1;
    localparam logic [CW-1:0] IDX_LAST   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(SORT_PHASES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   phase_cnt;
    logic [CW-1:0]   rd_cnt;
    logic            desc_q;
    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] even_nxt [DEPTH];
    logic [WIDTH-1:0] odd_nxt  [DEPTH];
    logic            in_xfer;
    logic            out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Even phase: pairs (0,1), (2,3), ...
    for (genvar p = 0; p < NPAIR_EVEN; p++) begin : g_even
        cmp_swap #(.WIDTH(WIDTH)) u_cs (
            .a       (mem[2*p]),
            .b       (mem[2*p+1]),
            .desc    (desc_q),
            .lo_slot (even_nxt[2*p]),
            .hi_slot (even_nxt[2*p+1])
        );
    end

    // Odd phase: pairs (1,2), (3,4), ...; the two end slots pass through.
    for (genvar p = 0; p < NPAIR_ODD; p++) begin : g_odd
        cmp_swap #(.WIDTH(WIDTH)) u_cs (
            .a       (mem[2*p+1]),
            .b       (mem[2*p+2]),
            .desc    (desc_q),
            .lo_slot (odd_nxt[2*p+1]),
            .hi_slot (odd_nxt[2*p+2])
        );
    end
    assign odd_nxt[0]       = mem[0];
    assign odd_nxt[DEPTH-1] = mem[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (wr_cnt == IDX_LAST)) state_nxt = SORT;
            end
            SORT: begin
                busy = 1'b1;
                if (phase_cnt == PHASE_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem[rd_cnt];
                out_last  = (rd_cnt == IDX_LAST);
                if (out_ready && out_last) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
        // Reset quiets the streams in the very cycle it is asserted.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_data  = '0;
            out_last  = 1'b0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            phase_cnt <= '0;
            rd_cnt    <= '0;
            desc_q    <= 1'b0;
        end else begin
            if (in_xfer) begin
                if (wr_cnt == '0) desc_q <= desc;
                wr_cnt <= (wr_cnt == IDX_LAST) ? '0 : wr_cnt + CW'(1);
            end
            if (state == SORT)
                phase_cnt <= (phase_cnt == PHASE_LAST) ? '0 : phase_cnt + CW'(1);
            if (out_xfer)
                rd_cnt <= out_last ? '0 : rd_cnt + CW'(1);
        end
    end

    // Array storage carries no reset; contents are rewritten by every batch.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mem[wr_cnt] <= in_data;
        end else if (state == SORT) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= phase_cnt[0] ? odd_nxt[i] : even_nxt[i];
        end
    end

endmodule

// File: tb/tb_stream_sorter.sv
// Directed table-driven bench for stream_sorter (WIDTH=3, DEPTH=8).
module tb_stream_sorter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       desc;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       out_last;
    logic       busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic            desc;
        logic            tog;
        logic            bp;
        logic [7:0][2:0] din;
        logic [7:0][2:0] exp;
    } rec_t;

    stream_sorter #(.WIDTH(3), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .desc      (desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic rec_t mk(input logic d, input logic t, input logic b,
                                input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input int e0, input int e1, input int e2, input int e3,
                                input int e4, input int e5, input int e6, input int e7);
        rec_t r;
        r.desc = d; r.tog = t; r.bp = b;
        r.din[0] = 3'(a0); r.din[1] = 3'(a1); r.din[2] = 3'(a2); r.din[3] = 3'(a3);
        r.din[4] = 3'(a4); r.din[5] = 3'(a5); r.din[6] = 3'(a6); r.din[7] = 3'(a7);
        r.exp[0] = 3'(e0); r.exp[1] = 3'(e1); r.exp[2] = 3'(e2); r.exp[3] = 3'(e3);
        r.exp[4] = 3'(e4); r.exp[5] = 3'(e5); r.exp[6] = 3'(e6); r.exp[7] = 3'(e7);
        return r;
    endfunction

    // Load 8 beats starting at a negedge; leaves the bench at the negedge after the last edge.
    task automatic load(input rec_t r, input logic keep_valid);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = r.din[i];
            desc     = (i == 0) ? r.desc : (r.tog ? ~desc : r.desc);
            check("load_in_ready", int'(in_ready), 1);
            step();
        end
        in_valid = keep_valid;
        in_data  = 3'b101;
        desc     = ~r.desc;
    endtask

    // Sort window then drain with optional 1,0,0,1,0,1 backpressure.
    task automatic sort_drain(input rec_t r);
        logic [5:0] pat;
        int         j;
        int         cyc;
        logic       prev_stall;
        logic [2:0] prev_data;
        logic       prev_last;
        pat = 6'b101001;
        for (int k = 0; k < 8; k++) begin
            check("sort_out_valid", int'(out_valid), 0);
            check("sort_in_ready", int'(in_ready), 0);
            check("sort_busy", int'(busy), 1);
            step();
        end
        j = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (j < 8 && cyc < 64) begin
            out_ready = r.bp ? pat[cyc % 6] : 1'b1;
            if (cyc == 0) check("first_out_valid", int'(out_valid), 1);
            check("drain_in_ready", int'(in_ready), 0);
            if (prev_stall) begin
                check("stall_data", int'(out_data), int'(prev_data));
                check("stall_last", int'(out_last), int'(prev_last));
            end
            if (out_valid && out_ready) begin
                check("out_data", int'(out_data), int'(r.exp[j]));
                check("out_last", int'(out_last), (j == 7) ? 1 : 0);
                j++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            step();
            cyc++;
        end
        check("drain_count", j, 8);
        out_ready = 1'b1;
        check("post_in_ready", int'(in_ready), 1);
        check("post_out_valid", int'(out_valid), 0);
        check("post_busy", int'(busy), 0);
    endtask

    rec_t tbl [5];
    rec_t sgn;
    rec_t fresh;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; desc = 1'b0; out_ready = 1'b1;

        sgn = mk(0, 0, 0, 3, 4, 7, 0, 2, 5, 1, 6,
`ifdef STREAM_SORTER_SIGNED_EN
                 4, 5, 6, 7, 0, 1, 2, 3);
`else
                 0, 1, 2, 3, 4, 5, 6, 7);
`endif
        tbl[0] = mk(0, 0, 0, 5, 3, 7, 0, 6, 1, 4, 2,  0, 1, 2, 3, 4, 5, 6, 7);
        tbl[1] = mk(1, 1, 0, 3, 3, 0, 7, 7, 1, 1, 5,  7, 7, 5, 3, 3, 1, 1, 0);
        tbl[2] = mk(0, 0, 1, 2, 6, 2, 0, 5, 5, 7, 1,  0, 1, 2, 2, 5, 5, 6, 7);
        tbl[3] = sgn;
        tbl[4] = mk(1, 0, 1, 0, 1, 2, 3, 4, 5, 6, 7,  7, 6, 5, 4, 3, 2, 1, 0);
        fresh  = mk(0, 0, 0, 7, 6, 5, 4, 3, 2, 1, 0,  0, 1, 2, 3, 4, 5, 6, 7);

        @(negedge clk);
        step();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", int'(in_ready), 1);

        for (int t = 0; t < 5; t++) begin
            load(tbl[t], 1'b0);
            sort_drain(tbl[t]);
        end

        // Reset in the middle of the sort, then a fresh batch.
        load(tbl[0], 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("midrst_release_ready", int'(in_ready), 1);
        for (int k = 0; k < 10; k++) begin
            check("midrst_no_valid", int'(out_valid), 0);
            step();
        end
        load(fresh, 1'b0);
        sort_drain(fresh);

        // Back-to-back with in_valid held high through sort and drain.
        load(tbl[1], 1'b1);
        sort_drain(tbl[1]);
        load(tbl[0], 1'b1);
        sort_drain(tbl[0]);
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
